// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter (instruction fetch vs. load/store).
// The request struct fields are sized to the 32-bit default port widths.
package sram_arb_pkg;

  localparam int WAIT_W     = 4;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port was denied.
// inst_prio rises once the count reaches MAX_WAIT, letting fetch beat data.
module sram_arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic inst_gnt,
  output logic inst_prio
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q;

  // NOTE: always_comb assigns every output a default first, so no path leaves a value held (no latch).
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!inst_req || inst_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign inst_prio = (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between CPU fetch and load/store ports.
// Optional SRAM_ARB_PERF_CNT_EN adds grant/conflict performance counters.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_data_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  logic      inst_prio;
  logic      inst_win;
  logic      data_win;
  sram_req_t win;

  logic      rd_pend_d;
  logic      rd_pend_q;
  owner_e    rd_owner_d;
  owner_e    rd_owner_q;

  sram_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inst_req  (inst_req),
    .inst_gnt  (inst_win),
    .inst_prio (inst_prio)
  );

  // Data wins unless fetch has waited MAX_WAIT cycles; nothing is granted in reset.
  always_comb begin
    data_win = 1'b0;
    inst_win = 1'b0;
    if (!reset) begin
      if (data_req && !(inst_prio && inst_req)) begin
        data_win = 1'b1;
      end else if (inst_req) begin
        inst_win = 1'b1;
      end
    end
  end

  always_comb begin
    win = '0;
    if (data_win) begin
      win.we    = data_we;
      win.addr  = ARB_ADDR_W'(data_addr);
      win.wdata = ARB_DATA_W'(data_wdata);
    end else if (inst_win) begin
      win.addr  = ARB_ADDR_W'(inst_addr);
    end
  end

  assign inst_gnt   = inst_win;
  assign data_gnt   = data_win;
  assign sram_en    = inst_win | data_win;
  assign sram_we    = win.we;
  assign sram_addr  = ADDR_W'(win.addr);
  assign sram_wdata = DATA_W'(win.wdata);

  // Track which port owns the read that returns next cycle; stores never respond.
  always_comb begin
    rd_pend_d  = sram_en & ~sram_we;
    rd_owner_d = data_win ? OWN_DATA : OWN_INST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_INST;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gated by reset so a read in flight when reset arrives never reports valid.
  assign inst_rvalid = ~reset & rd_pend_q & (rd_owner_q == OWN_INST);
  assign data_rvalid = ~reset & rd_pend_q & (rd_owner_q == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] perf_inst_cnt_d;
  logic [31:0] perf_inst_cnt_q;
  logic [31:0] perf_data_cnt_d;
  logic [31:0] perf_data_cnt_q;
  logic [31:0] perf_conflict_cnt_d;
  logic [31:0] perf_conflict_cnt_q;

  always_comb begin
    perf_inst_cnt_d     = perf_inst_cnt_q + {31'd0, inst_win};
    perf_data_cnt_d     = perf_data_cnt_q + {31'd0, data_win};
    perf_conflict_cnt_d = perf_conflict_cnt_q + {31'd0, inst_req & data_req};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_inst_cnt_q     <= '0;
      perf_data_cnt_q     <= '0;
      perf_conflict_cnt_q <= '0;
    end else begin
      perf_inst_cnt_q     <= perf_inst_cnt_d;
      perf_data_cnt_q     <= perf_data_cnt_d;
      perf_conflict_cnt_q <= perf_conflict_cnt_d;
    end
  end

  assign perf_inst_cnt     = perf_inst_cnt_q;
  assign perf_data_cnt     = perf_data_cnt_q;
  assign perf_conflict_cnt = perf_conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scoreboard bench for sram_port_arbiter: drivers push expected read data,
// a negedge monitor pops and compares whenever an rvalid appears.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              inst_req = 1'b0;
  logic [ADDR_W-1:0] inst_addr = '0;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req = 1'b0;
  logic              data_we = 1'b0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] data_wdata = '0;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0]       perf_inst_cnt;
  logic [31:0]       perf_data_cnt;
  logic [31:0]       perf_conflict_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_inst_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic [DATA_W-1:0] mem[logic [ADDR_W-1:0]];

  sram_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_gnt          (inst_gnt),
    .inst_rvalid       (inst_rvalid),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_we           (data_we),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_gnt          (data_gnt),
    .data_rvalid       (data_rvalid),
    .data_rdata        (data_rdata),
    .sram_en           (sram_en),
    .sram_we           (sram_we),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_rdata        (sram_rdata)
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    .perf_inst_cnt     (perf_inst_cnt),
    .perf_data_cnt     (perf_data_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] = sram_wdata;
      else sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : '0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (inst_rvalid) begin
      if (exp_inst_q.size() == 0) check("inst_rvalid unexpected", {31'd0, inst_rvalid}, 32'd0);
      else check("inst_rdata", inst_rdata, exp_inst_q.pop_front());
    end
    if (data_rvalid) begin
      if (exp_data_q.size() == 0) check("data_rvalid unexpected", {31'd0, data_rvalid}, 32'd0);
      else check("data_rdata", data_rdata, exp_data_q.pop_front());
    end
  end

  // One cycle of stimulus; exp_wait < 0 skips the starvation-counter check.
  task automatic step(input string name,
                      input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                      input logic eig, input logic edg, input logic [31:0] erd, input int exp_wait);
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
    @(negedge clk);
    check({name, " inst_gnt"}, {31'd0, inst_gnt}, {31'd0, eig});
    check({name, " data_gnt"}, {31'd0, data_gnt}, {31'd0, edg});
    check({name, " sram_en"}, {31'd0, sram_en}, {31'd0, eig | edg});
    check({name, " sram_we"}, {31'd0, sram_we}, {31'd0, edg & dwe});
    check({name, " sram_addr"}, sram_addr, edg ? da : (eig ? ia : 32'd0));
    check({name, " sram_wdata"}, sram_wdata, edg ? dwd : 32'd0);
    if (exp_wait >= 0) check({name, " wait_cnt"}, {28'd0, dut.u_starve.wait_cnt_q}, exp_wait);
    if (eig) exp_inst_q.push_back(erd);
    if (edg && !dwe) exp_data_q.push_back(erd);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step("idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, -1);
  endtask

  initial begin
    mem[32'h1c000000] = 32'h02800421;
    mem[32'h00000000] = 32'h11111111;
    mem[32'h00000004] = 32'h22222222;
    mem[32'h00000008] = 32'h33333333;
    mem[32'h00000040] = 32'hA5A50040;

    // Reset holds off grants even with both ports requesting.
    inst_req = 1'b1; data_req = 1'b1;
    @(negedge clk);
    check("reset inst_gnt", {31'd0, inst_gnt}, 32'd0);
    check("reset data_gnt", {31'd0, data_gnt}, 32'd0);
    check("reset sram_en", {31'd0, sram_en}, 32'd0);
    check("reset sram_we", {31'd0, sram_we}, 32'd0);
    check("reset inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
    check("reset data_rvalid", {31'd0, data_rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;

    step("fetch", 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h02800421, 0);
    idle();

    step("store", 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, -1);
    step("load", 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, -1);
    idle();

    step("b2b0", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11111111, -1);
    step("b2b1", 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h22222222, -1);
    step("b2b2", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h33333333, -1);
    idle();

    // Fresh reset so the perf counters cover only the contention run.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int exp_wait_tbl[8] = '{0, 1, 2, 3, 4, 0, 1, 2};
      logic ig;
      ig = (i == 4);
      step("contend", 1'b1, 32'h1c000000, 1'b1, 1'b0, 32'h40, 32'h0,
           ig, ~ig, ig ? 32'h02800421 : 32'hA5A50040, exp_wait_tbl[i]);
    end
    idle();
    step("post_contend", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
`ifdef SRAM_ARB_PERF_CNT_EN
    check("perf_inst_cnt", perf_inst_cnt, 32'd1);
    check("perf_data_cnt", perf_data_cnt, 32'd7);
    check("perf_conflict_cnt", perf_conflict_cnt, 32'd8);
`endif

    // Load granted, then reset next cycle: its response must be dropped.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h40;
    @(negedge clk);
    check("rstread data_gnt", {31'd0, data_gnt}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstread data_rvalid", {31'd0, data_rvalid}, 32'd0);
      check("rstread inst_gnt", {31'd0, inst_gnt}, 32'd0);
      check("rstread data_gnt", {31'd0, data_gnt}, 32'd0);
      check("rstread sram_en", {31'd0, sram_en}, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("rstread wait_cnt", {28'd0, dut.u_starve.wait_cnt_q}, 32'd0);
    check("rstread data_rvalid after", {31'd0, data_rvalid}, 32'd0);
    @(posedge clk); #1;
    idle();
    idle();

    check("inst queue drained", exp_inst_q.size(), 32'd0);
    check("data queue drained", exp_data_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
